// File: rtl/rgb_gray_world_awb.sv
// Gray-world auto white balance: per-frame channel sums feed a sequential divider
// in vertical blanking; a 3-stage datapath applies saturating R/B gains.
module rgb_gray_world_awb #(
    parameter int unsigned H_DISP = 640,
    parameter int unsigned V_DISP = 480,
    parameter int unsigned SUM_W  = 27,
    parameter int unsigned GAIN_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RGB888_hsync,
    input  logic              RGB888_vsync,
    input  logic [23:0]       RGB888_data,
    input  logic              RGB888_de,
    input  logic              awb_en,
    output logic              AWB_hsync,
    output logic              AWB_vsync,
    output logic [23:0]       AWB_data,
    output logic              AWB_de,
    output logic [GAIN_W-1:0] gain_r,
    output logic [GAIN_W-1:0] gain_b,
    output logic              awb_busy
);
    localparam int unsigned FRAME_PIX = H_DISP * V_DISP;
    localparam int unsigned PROD_W    = 8 + GAIN_W;
    localparam int unsigned DQ_W      = SUM_W + 8;
    localparam int unsigned CNT_W     = $clog2(DQ_W);
    localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(256);
    localparam logic [GAIN_W-1:0] GAIN_MAX = '1;

    typedef enum logic [1:0] {IDLE, DIV_R, DIV_B, WAIT_COMMIT} state_t;

    function automatic logic [7:0] sat8(input logic [PROD_W-1:0] p);
        logic [PROD_W-1:0] q;
        q = p >> 8;
        return (q > PROD_W'(255)) ? 8'hFF : q[7:0];
    endfunction

    function automatic logic [GAIN_W-1:0] clamp_gain(input logic [DQ_W-1:0] q,
                                                     input logic [SUM_W-1:0] d);
        if (d == '0 || q > DQ_W'(GAIN_MAX))
            return GAIN_MAX;
        return q[GAIN_W-1:0];
    endfunction

    logic              s1_hs, s1_vs, s1_de, s2_hs, s2_vs, s2_de;
    logic [23:0]       s1_pix;
    logic [GAIN_W-1:0] s1_gr, s1_gb;
    logic [PROD_W-1:0] s2_pr, s2_pg, s2_pb;

    // Pixel datapath: S1 register/gain select, S2 multiply, S3 shift and saturate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hs <= 1'b0; s1_vs <= 1'b0; s1_de <= 1'b0;
            s2_hs <= 1'b0; s2_vs <= 1'b0; s2_de <= 1'b0;
            AWB_hsync <= 1'b0; AWB_vsync <= 1'b0; AWB_de <= 1'b0;
            s1_pix <= '0; s1_gr <= UNITY; s1_gb <= UNITY;
            s2_pr <= '0; s2_pg <= '0; s2_pb <= '0;
            AWB_data <= '0;
        end else begin
            s1_hs  <= RGB888_hsync;
            s1_vs  <= RGB888_vsync;
            s1_de  <= RGB888_de;
            s1_pix <= RGB888_de ? RGB888_data : '0;
            s1_gr  <= awb_en ? gain_r : UNITY;
            s1_gb  <= awb_en ? gain_b : UNITY;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
            s2_de  <= s1_de;
            s2_pr  <= PROD_W'(s1_pix[23:16]) * PROD_W'(s1_gr);
            s2_pg  <= PROD_W'({s1_pix[15:8], 8'h00});
            s2_pb  <= PROD_W'(s1_pix[7:0]) * PROD_W'(s1_gb);
            AWB_hsync <= s2_hs;
            AWB_vsync <= s2_vs;
            AWB_de    <= s2_de;
            AWB_data  <= s2_de ? {sat8(s2_pr), sat8(s2_pg), sat8(s2_pb)} : '0;
        end
    end

    logic             vs_d, vs_rise, de_seen, frame_ok;
    logic [SUM_W-1:0] sum_r, sum_g, sum_b, pix_cnt;

    assign vs_rise  = RGB888_vsync & ~vs_d;
    assign frame_ok = (pix_cnt == SUM_W'(FRAME_PIX));

    // Frame statistics; a frame ends on the registered rising edge of vsync
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d <= 1'b0; de_seen <= 1'b0;
            sum_r <= '0; sum_g <= '0; sum_b <= '0; pix_cnt <= '0;
        end else begin
            vs_d <= RGB888_vsync;
            if (vs_rise) begin
                de_seen <= 1'b0;
                sum_r <= '0; sum_g <= '0; sum_b <= '0; pix_cnt <= '0;
            end else if (RGB888_de) begin
                de_seen <= 1'b1;
                sum_r   <= sum_r + SUM_W'(RGB888_data[23:16]);
                sum_g   <= sum_g + SUM_W'(RGB888_data[15:8]);
                sum_b   <= sum_b + SUM_W'(RGB888_data[7:0]);
                pix_cnt <= pix_cnt + SUM_W'(1);
            end
        end
    end

    state_t            state;
    logic [SUM_W-1:0]  snap_g, snap_b, divisor, rem, rem_nx;
    logic [DQ_W-1:0]   dq, dq_nx;
    logic [SUM_W:0]    rem_sh;
    logic              div_ge, pend_valid;
    logic [CNT_W-1:0]  bit_cnt;
    logic [GAIN_W-1:0] pend_r, pend_b;

    // One restoring-division step: dq shifts the dividend out and the quotient in
    always_comb begin
        rem_sh = {rem, dq[DQ_W-1]};
        div_ge = (rem_sh >= {1'b0, divisor});
        rem_nx = div_ge ? SUM_W'(rem_sh - {1'b0, divisor}) : SUM_W'(rem_sh);
        dq_nx  = {dq[DQ_W-2:0], div_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE; awb_busy <= 1'b0;
            gain_r <= UNITY; gain_b <= UNITY;
            pend_r <= UNITY; pend_b <= UNITY; pend_valid <= 1'b0;
            snap_g <= '0; snap_b <= '0; divisor <= '0;
            dq <= '0; rem <= '0; bit_cnt <= '0;
        end else if (vs_rise) begin
            // Frame boundary: commit held gains, abort any division, maybe restart
            if (pend_valid || state == WAIT_COMMIT) begin
                gain_r <= pend_r;
                gain_b <= pend_b;
            end
            pend_valid <= 1'b0;
            rem        <= '0;
            bit_cnt    <= '0;
            if (frame_ok) begin
                snap_g   <= sum_g;
                snap_b   <= sum_b;
                divisor  <= sum_r;
                dq       <= {sum_g, 8'h00};
                state    <= DIV_R;
                awb_busy <= 1'b1;
            end else begin
                state    <= IDLE;
                awb_busy <= 1'b0;
            end
        end else begin
            case (state)
                DIV_R, DIV_B: begin
                    rem     <= rem_nx;
                    dq      <= dq_nx;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(DQ_W - 1)) begin
                        rem     <= '0;
                        bit_cnt <= '0;
                        if (state == DIV_R) begin
                            pend_r  <= clamp_gain(dq_nx, divisor);
                            dq      <= {snap_g, 8'h00};
                            divisor <= snap_b;
                            state   <= DIV_B;
                        end else begin
                            pend_b   <= clamp_gain(dq_nx, divisor);
                            state    <= WAIT_COMMIT;
                            awb_busy <= 1'b0;
                        end
                    end
                end
                WAIT_COMMIT: begin
                    // Gains only move while the next frame has not started
                    if (de_seen || RGB888_de) begin
                        pend_valid <= 1'b1;
                    end else begin
                        gain_r <= pend_r;
                        gain_b <= pend_b;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rgb_gray_world_awb.sv
// Bench for rgb_gray_world_awb: per-cycle scoreboard against a frame-level
// gray-world model, a table of uniform frames and hand-written corner sequences.
module tb_rgb_gray_world_awb;
    localparam int unsigned H_DISP = 16;
    localparam int unsigned V_DISP = 4;
    localparam int unsigned SUM_W  = 16;
    localparam int unsigned GAIN_W = 10;
    localparam int FRAME_PIX = H_DISP * V_DISP;
    localparam int DIV_CYC   = 2 * (SUM_W + 8);

    logic clk = 1'b0, rst_n = 1'b0;
    logic hs = 1'b0, vs = 1'b0, de = 1'b0, en = 1'b1;
    logic [23:0] din = 24'h0;
    logic AWB_hsync, AWB_vsync, AWB_de, awb_busy;
    logic [23:0] AWB_data;
    logic [GAIN_W-1:0] gain_r, gain_b;

    rgb_gray_world_awb #(.H_DISP(H_DISP), .V_DISP(V_DISP), .SUM_W(SUM_W), .GAIN_W(GAIN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .RGB888_hsync(hs), .RGB888_vsync(vs), .RGB888_data(din), .RGB888_de(de),
        .awb_en(en),
        .AWB_hsync(AWB_hsync), .AWB_vsync(AWB_vsync), .AWB_data(AWB_data), .AWB_de(AWB_de),
        .gain_r(gain_r), .gain_b(gain_b), .awb_busy(awb_busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic h; logic v; logic d; logic [23:0] data; } out_t;
    typedef struct { logic [23:0] pix; logic en; logic [23:0] exp_out; int exp_gr; int exp_gb; } vec_t;

    out_t exp_q[$];
    vec_t vecs[7];
    int checks = 0, errors = 0;
    // Frame-level model: active gains, pending result and its lifecycle
    int act_r, act_b, pend_r, pend_b, pst, t, acc_n;
    longint acc_r, acc_g, acc_b;
    bit seen;
    logic prev_vs;
    logic [23:0] last_out;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic int gain_of(input longint num, input longint den);
        longint q;
        if (den == 0) return 1023;
        q = (num * 256) / den;
        return (q > 1023) ? 1023 : int'(q);
    endfunction

    function automatic logic [23:0] apply_gain(input logic [23:0] p, input int gr, input int gb);
        int r, g, b;
        r = (int'(p[23:16]) * gr) / 256;
        if (r > 255) r = 255;
        g = int'(p[15:8]);
        b = (int'(p[7:0]) * gb) / 256;
        if (b > 255) b = 255;
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    task automatic model_update(input logic v, input logic d, input logic [23:0] px);
        if (pst == 1) t++;
        if (v && !prev_vs) begin
            if (pst == 2 || (pst == 1 && t > DIV_CYC)) begin
                act_r = pend_r;
                act_b = pend_b;
            end
            if (acc_n == FRAME_PIX) begin
                pend_r = gain_of(acc_g, acc_r);
                pend_b = gain_of(acc_g, acc_b);
                pst = 1; t = 0; seen = 0;
            end else begin
                pst = 0;
            end
            acc_r = 0; acc_g = 0; acc_b = 0; acc_n = 0;
        end else begin
            if (d) begin
                acc_r += longint'(px[23:16]);
                acc_g += longint'(px[15:8]);
                acc_b += longint'(px[7:0]);
                acc_n++;
            end
            if (pst == 1) begin
                if (d) seen = 1;
                if (t == DIV_CYC + 1) begin
                    if (!seen) begin
                        act_r = pend_r; act_b = pend_b; pst = 0;
                    end else begin
                        pst = 2;
                    end
                end
            end
        end
        prev_vs = v;
    endtask

    task automatic step(input logic h, input logic v, input logic d, input logic [23:0] px);
        out_t e, n;
        int gr, gb;
        @(negedge clk);
        e = exp_q.pop_front();
        chk("pipe", 32'({AWB_hsync, AWB_vsync, AWB_de, AWB_data}), 32'({e.h, e.v, e.d, e.data}));
        if (AWB_de) last_out = AWB_data;
        chk("gain_r", 32'(gain_r), 32'(act_r));
        chk("gain_b", 32'(gain_b), 32'(act_b));
        chk("busy", 32'(awb_busy), 32'((pst == 1 && t < DIV_CYC) ? 1 : 0));
        hs = h; vs = v; de = d; din = px;
        gr = en ? act_r : 256;
        gb = en ? act_b : 256;
        n.h = h; n.v = v; n.d = d;
        n.data = d ? apply_gain(px, gr, gb) : 24'h0;
        exp_q.push_back(n);
        model_update(v, d, px);
    endtask

    task automatic do_reset();
        out_t z;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_data", 32'(AWB_data), 32'h0);
        chk("rst_sync", 32'({AWB_hsync, AWB_vsync, AWB_de}), 32'h0);
        chk("rst_gain_r", 32'(gain_r), 32'd256);
        chk("rst_gain_b", 32'(gain_b), 32'd256);
        chk("rst_busy", 32'(awb_busy), 32'h0);
        hs = 1'b0; vs = 1'b0; de = 1'b0; din = 24'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        act_r = 256; act_b = 256; pend_r = 256; pend_b = 256;
        pst = 0; t = 0; seen = 0; prev_vs = 1'b0;
        acc_r = 0; acc_g = 0; acc_b = 0; acc_n = 0;
        z.h = 1'b0; z.v = 1'b0; z.d = 1'b0; z.data = 24'h0;
        exp_q.delete();
        repeat (3) exp_q.push_back(z);
    endtask

    task automatic send_lines(input logic [23:0] pix, input bit rnd, input int npix);
        int sent = 0;
        logic [23:0] p;
        for (int l = 0; l < int'(V_DISP); l++) begin
            step(1'b1, 1'b0, 1'b0, 24'h0);
            for (int x = 0; x < int'(H_DISP); x++) begin
                if (sent < npix) begin
                    if (rnd && $urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b0, 24'h0);
                    p = rnd ? 24'($urandom) : pix;
                    step(1'b0, 1'b0, 1'b1, p);
                    sent++;
                end else begin
                    step(1'b0, 1'b0, 1'b0, 24'h0);
                end
            end
            step(1'b0, 1'b0, 1'b0, 24'h0);
        end
    endtask

    task automatic send_vsync(input int vb);
        step(1'b0, 1'b1, 1'b0, 24'h0);
        step(1'b0, 1'b1, 1'b0, 24'h0);
        repeat (vb) step(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    initial begin
        vecs[0] = '{24'h408020, 1'b1, 24'h408020, 512, 1023};
        vecs[1] = '{24'h408020, 1'b1, 24'h80807F, 512, 1023};
        vecs[2] = '{24'hC8C864, 1'b1, 24'hFFC8FF, 256, 512};
        vecs[3] = '{24'h006432, 1'b1, 24'h006464, 1023, 512};
        vecs[4] = '{24'h0A1428, 1'b0, 24'h0A1428, 512, 128};
        vecs[5] = '{24'h0A1428, 1'b0, 24'h0A1428, 512, 128};
        vecs[6] = '{24'h0A1428, 1'b1, 24'h141414, 512, 128};

        do_reset();

        // Latency and first-edge skip
        step(1'b1, 1'b0, 1'b1, 24'h804020);
        step(1'b0, 1'b0, 1'b0, 24'h0);
        step(1'b0, 1'b0, 1'b0, 24'h0);
        @(posedge clk);
        #1;
        chk("lat_data", 32'(AWB_data), 32'h804020);
        chk("lat_de", 32'(AWB_de), 32'h1);
        chk("lat_hsync", 32'(AWB_hsync), 32'h1);
        step(1'b0, 1'b0, 1'b0, 24'h0);
        send_vsync(60);
        chk("first_edge_gr", 32'(gain_r), 32'd256);
        chk("first_edge_gb", 32'(gain_b), 32'd256);

        for (int i = 0; i < 7; i++) begin
            en = vecs[i].en;
            last_out = 24'h0;
            send_lines(vecs[i].pix, 1'b0, FRAME_PIX);
            send_vsync(60);
            chk("tbl_out", 32'(last_out), 32'(vecs[i].exp_out));
            chk("tbl_gr", 32'(gain_r), 32'(vecs[i].exp_gr));
            chk("tbl_gb", 32'(gain_b), 32'(vecs[i].exp_gb));
        end

        repeat (6) begin
            en = 1'($urandom_range(0, 1));
            send_lines(24'h0, 1'b1, FRAME_PIX);
            send_vsync(60);
        end

        // Short frame keeps the gains
        begin
            int sr, sb;
            en = 1'b1;
            sr = act_r; sb = act_b;
            send_lines(24'h336699, 1'b0, FRAME_PIX - 1);
            send_vsync(60);
            chk("short_gr", 32'(gain_r), 32'(sr));
            chk("short_gb", 32'(gain_b), 32'(sb));

            // Next frame starts before the divider is done: hold until next edge
            send_lines(24'h643219, 1'b0, FRAME_PIX);
            send_vsync(10);
            send_lines(24'h101010, 1'b0, 40);
            chk("hold_gr", 32'(gain_r), 32'(sr));
            chk("hold_gb", 32'(gain_b), 32'(sb));
            send_vsync(60);
            chk("commit_gr", 32'(gain_r), 32'd128);
            chk("commit_gb", 32'(gain_b), 32'd512);
        end

        // Vsync edge mid-division aborts the result
        send_lines(24'h50A028, 1'b0, FRAME_PIX);
        send_vsync(10);
        chk("busy_mid", 32'(awb_busy), 32'h1);
        send_vsync(60);
        chk("abort_busy", 32'(awb_busy), 32'h0);
        chk("abort_gr", 32'(gain_r), 32'd128);
        chk("abort_gb", 32'(gain_b), 32'd512);

        // Reset in the middle of active pixels
        repeat (5) step(1'b0, 1'b0, 1'b1, 24'h50A028);
        do_reset();
        send_lines(24'h50A028, 1'b0, 20);
        send_vsync(60);
        chk("post_rst_gr", 32'(gain_r), 32'd256);
        chk("post_rst_gb", 32'(gain_b), 32'd256);
        send_lines(24'h50A028, 1'b0, FRAME_PIX);
        send_vsync(60);
        chk("final_gr", 32'(gain_r), 32'd512);
        chk("final_gb", 32'(gain_b), 32'd1023);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
